// File: rtl/tff_stream_decoder_pkg.sv
// Shared types and constants for the toggle-encoded stream decoder.
package tff_stream_decoder_pkg;

    // Default payload width of one frame
    localparam int DATA_W_DEFAULT = 8;

    // Frame-collection FSM states
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

endpackage

// File: rtl/tff_edge_detect.sv
// Recovers the sender's bit stream from a toggle-encoded line.
// A toggle of the line between two strobed samples means a '1'.
module tff_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic q_in,
    output logic t_bit,
    output logic t_stb
);

    logic q_prev_reg;

    // Remember the line level seen at the last strobed sample
    always_ff @(posedge clk) begin
        if (rst) begin
            q_prev_reg <= 1'b0;
        end else if (en) begin
            q_prev_reg <= q_in;
        end
    end

    // t_bit is only meaningful on cycles where t_stb is high
    assign t_bit = q_in ^ q_prev_reg;
    assign t_stb = en;

endmodule

// File: rtl/tff_stream_decoder.sv
// Frame decoder: a start toggle followed by DATA_W payload bits, LSB first.
// Completed frames land in a single-entry output buffer with a
// valid/ready handshake; frames arriving while the buffer is full are
// dropped and flagged with a sticky overrun.
module tff_stream_decoder
    import tff_stream_decoder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              q_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t             state_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  shift_next;
    logic [DATA_W-1:0]  out_data_reg;
    logic               out_valid_reg;
    logic               overrun_reg;
    logic               t_bit;
    logic               t_stb;
    logic               frame_done;

    tff_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .q_in  (q_in),
        .t_bit (t_bit),
        .t_stb (t_stb)
    );

    // Shift register with the current decoded bit dropped into slot bit_cnt;
    // on the last bit this is also the completed frame word.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_slot
            assign shift_next[gi] = (bit_cnt_reg == CNT_W'(gi)) ? t_bit : shift_reg[gi];
        end
    endgenerate

    assign frame_done = t_stb && (state_reg == DATA) && (bit_cnt_reg == LAST_BIT);

    // Frame FSM, shift register and output buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (t_stb) begin
                case (state_reg)
                    IDLE: begin
                        if (t_bit) begin
                            state_reg   <= DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg <= shift_next;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_reg   <= IDLE;
                            bit_cnt_reg <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_reg   <= IDLE;
                        bit_cnt_reg <= '0;
                    end
                endcase
            end

            // A slot frees up either when empty or when drained this cycle
            if (frame_done && (!out_valid_reg || out_ready)) begin
                out_data_reg  <= shift_next;
                out_valid_reg <= 1'b1;
            end else if (frame_done) begin
                overrun_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg == DATA);

endmodule

// File: tb/tb_tff_stream_decoder.sv
// Directed bench for tff_stream_decoder (DATA_W = 8).
module tb_tff_stream_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       q_in = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       overrun;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    logic tb_q = 1'b0;   // line level the bench is currently driving

    tff_stream_decoder #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .q_in      (q_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", n_vec, tag, obs, exp);
    endtask

    // One clock with the given strobe/line, outputs sampled 1 time unit later
    task automatic sample(input logic e, input logic q);
        en   = e;
        q_in = q;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        en   = 1'b1;
        q_in = 1'b0;
        tb_q = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b0;
    endtask

    // Start toggle then 8 payload bits LSB first; out_ready switches to
    // rdy_last on the cycle of the final bit.
    task automatic send_frame(input logic [7:0] d, input logic rdy_last);
        tb_q = ~tb_q;
        sample(1'b1, tb_q);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) out_ready = rdy_last;
            tb_q = tb_q ^ d[i];
            sample(1'b1, tb_q);
        end
    endtask

    logic [8:0] vec_a5;

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 16'(out_valid), 16'h0);
        check("rst_data", 16'(out_data), 16'h00);
        check("rst_overrun", 16'(overrun), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);

        // Explicit line vector: start then 0xA5, en every cycle, ready high
        vec_a5 = 9'b1_0011_1001;   // bit 0 is the first sample
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sample(1'b1, vec_a5[i]);
            if (i == 0) check("a5_busy_start", 16'(busy), 16'h1);
            if (i == 7) check("a5_valid_early", 16'(out_valid), 16'h0);
        end
        check("a5_valid", 16'(out_valid), 16'h1);
        check("a5_data", 16'(out_data), 16'hA5);
        check("a5_busy_end", 16'(busy), 16'h0);
        check("a5_overrun", 16'(overrun), 16'h0);
        sample(1'b0, 1'b1);
        check("a5_valid_one_cycle", 16'(out_valid), 16'h0);

        // Same stream with en gaps; line wiggles during gaps and must be ignored
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sample(1'b1, vec_a5[i]);
            if (i < 8) begin
                sample(1'b0, ~vec_a5[i]);
                if (i == 3) check("gap_busy", 16'(busy), 16'h1);
                if (i == 6) check("gap_no_valid", 16'(out_valid), 16'h0);
            end
        end
        check("gap_valid", 16'(out_valid), 16'h1);
        check("gap_data", 16'(out_data), 16'hA5);
        sample(1'b0, vec_a5[8]);
        check("gap_valid_clear", 16'(out_valid), 16'h0);

        // Back-to-back frames with consumer stalled
        do_reset();
        out_ready = 1'b0;
        send_frame(8'h3C, 1'b0);
        check("ovr_first_valid", 16'(out_valid), 16'h1);
        check("ovr_first_data", 16'(out_data), 16'h3C);
        check("ovr_first_flag", 16'(overrun), 16'h0);
        send_frame(8'hFF, 1'b0);
        check("ovr_kept_data", 16'(out_data), 16'h3C);
        check("ovr_flag", 16'(overrun), 16'h1);
        check("ovr_still_valid", 16'(out_valid), 16'h1);
        out_ready = 1'b1;
        sample(1'b0, tb_q);
        check("ovr_drained", 16'(out_valid), 16'h0);
        check("ovr_data_after", 16'(out_data), 16'h3C);
        check("ovr_sticky", 16'(overrun), 16'h1);

        // Reset mid-frame discards the partial frame
        do_reset();
        out_ready = 1'b1;
        tb_q = ~tb_q;
        sample(1'b1, tb_q);
        for (int i = 0; i < 4; i++) begin
            tb_q = tb_q ^ i[0];
            sample(1'b1, tb_q);
        end
        check("mid_busy_before_rst", 16'(busy), 16'h1);
        do_reset();
        check("mid_busy_after_rst", 16'(busy), 16'h0);
        check("mid_overrun_cleared", 16'(overrun), 16'h0);
        for (int i = 0; i < 10; i++) begin
            sample(1'b1, tb_q);
            if (i == 9) check("mid_no_valid", 16'(out_valid), 16'h0);
        end
        send_frame(8'h5A, 1'b1);
        check("mid_next_valid", 16'(out_valid), 16'h1);
        check("mid_next_data", 16'(out_data), 16'h5A);

        // Constant line: no start toggle, nothing happens
        do_reset();
        for (int i = 0; i < 20; i++) begin
            sample(1'b1, 1'b0);
            check("const_busy", 16'(busy), 16'h0);
        end
        check("const_valid", 16'(out_valid), 16'h0);

        // Completion coincides with handshake of the previous byte
        do_reset();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0);
        check("hs_first_data", 16'(out_data), 16'h11);
        send_frame(8'h22, 1'b1);
        check("hs_new_data", 16'(out_data), 16'h22);
        check("hs_valid_held", 16'(out_valid), 16'h1);
        check("hs_no_overrun", 16'(overrun), 16'h0);
        sample(1'b0, tb_q);
        check("hs_drained", 16'(out_valid), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
